mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port, round-robin arbiter and sequencer that shares the single external data-memory port (SRAM controller, 32-bit word interface with request/ack) between the instruction-fetch stage and the load/store unit. It registers the winning request, drives the memory-side strobes until the memory acknowledges or a timeout expires, then returns a one-cycle acknowledge with read data (or an error flag) to the granted requester. It sits between the pipeline (IF stage, `lsu`) and the memory controller.

## Interface
- `TIMEOUT`, default 64: maximum ACCESS cycles waited for `i_mem_ack` before aborting (range 2..255).
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-low reset.
- `i_if_req`  in  1  fetch read request, level.
- `i_if_addr`  in  32  fetch byte address.
- `o_if_ack`  out  1  one-cycle fetch completion pulse.
- `o_if_rdata`  out  32  fetch read data, valid with `o_if_ack`.
- `i_ls_req`  in  1  load/store request, level.
- `i_ls_wren`  in  1  1 = store, 0 = load.
- `i_ls_addr`  in  32  load/store byte address.
- `i_ls_wdata`  in  32  store data.
- `i_ls_bmask`  in  4  store byte-lane mask.
- `o_ls_ack`  out  1  one-cycle load/store completion pulse.
- `o_ls_rdata`  out  32  load data, valid with `o_ls_ack`; 0 for stores.
- `o_err`  out  1  qualifies the current ack pulse: 1 = access timed out.
- `o_mem_addr`  out  32  registered address to memory.
- `o_mem_wdata`  out  32  registered write data.
- `o_mem_bmask`  out  4  byte mask; 4'b1111 on reads.
- `o_mem_wren`  out  1  write strobe, held through ACCESS.
- `o_mem_rden`  out  1  read strobe, held through ACCESS.
- `i_mem_rdata`  in  32  memory read data, valid with `i_mem_ack`.
- `i_mem_ack`  in  1  memory completion.
- `o_busy`  out  1  1 whenever state is not IDLE.
- `o_grant`  out  2  {ls, if} one-hot owner of the current transaction; 2'b00 in IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample requests. Only one pending: grant it. Both pending: grant the port not granted last (`last_gnt` register). Grant: latch addr/wdata/bmask/wren of winner (fetch forces wren=0, bmask=4'b1111, wdata=0), set `o_grant`, clear timeout counter, go ACCESS, update `last_gnt`. None pending: stay.
- ACCESS: `o_mem_rden`=~wren, `o_mem_wren`=wren, driven from latched registers. Counter increments each ACCESS cycle. `i_mem_ack`=1: capture `i_mem_rdata` (forced 0 for stores), err=0, go RESP. Else counter reaches TIMEOUT-1: rdata=0, err=1, go RESP. Ack takes priority over timeout in the same cycle.
- RESP: strobes low; pulse `o_if_ack` or `o_ls_ack` per `o_grant` with registered rdata and `o_err`; go IDLE.
- Requester rule: hold req and request fields stable from assertion until the ack cycle; req still high in the IDLE cycle after RESP is a new request.
- Request inputs are ignored outside IDLE; `i_mem_ack` is ignored outside ACCESS.
- Non-granted port's ack and rdata stay 0.

## Timing
- Reset (i_rst=0 at edge): state IDLE, `last_gnt`=fetch (so first tie goes to load/store), counter 0, every output 0.
- Reset in ACCESS/RESP aborts the transaction: no ack is issued; strobes low the next cycle.
- Latency: request in IDLE cycle N -> strobes from N+1 -> ack at edge M -> requester ack in cycle M+1 -> IDLE at M+2. Zero-wait memory (ack in first ACCESS cycle): requester ack 2 cycles after request sample; minimum issue interval 3 cycles per transaction.
- Timeout: strobes held exactly TIMEOUT cycles, then RESP with `o_err`=1.
- Under continuous dual requests, grants alternate strictly LS, IF, LS, IF...
- Counter width 8 bits; no wrap occurs since it is cleared on every grant.

## Test plan
- Reset: drive i_rst=0 for 2 cycles with both reqs high -> all outputs 0, `o_busy`=0; release -> first grant `o_grant`=2'b10 (LS).
- Single fetch, memory acks in first ACCESS cycle with 0xDEADBEEF at addr 0x100 -> `o_mem_rden`=1 for 1 cycle, `o_mem_bmask`=4'hF, `o_if_ack` pulse with 0xDEADBEEF, `o_err`=0, 2 cycles after request.
- Store addr 0x2004, data 0x12345678, mask 4'b0011, memory ack after 3 cycles -> `o_mem_wren` held 3 cycles with latched fields, `o_ls_ack` pulse with `o_ls_rdata`=0.
- Both reqs held for 4 transactions -> grant order LS, IF, LS, IF; each ack goes only to the owner.
- TIMEOUT=4, memory never acks -> strobe high exactly 4 cycles, then `o_ls_ack`=1, `o_err`=1, rdata 0; next request proceeds normally.
- Change `i_if_addr` and assert `i_ls_req` during ACCESS -> `o_mem_addr` unchanged; LS serviced only after return to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one 32-bit request/ack memory port between
// instruction fetch and the load/store unit, with a per-access timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_wren,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_ack,
  output logic [31:0] o_ls_rdata,
  output logic        o_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_ls;   // 1 = load/store owned the previous transaction
  logic [7:0] cnt;
  logic       pick_ls;

  // A tie goes to whichever port did not win last time.
  always_comb begin
    pick_ls = i_ls_req & (~i_if_req | ~last_ls);
  end

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      last_ls     <= 1'b0;
      cnt         <= '0;
      o_if_ack    <= 1'b0;
      o_if_rdata  <= '0;
      o_ls_ack    <= 1'b0;
      o_ls_rdata  <= '0;
      o_err       <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_rden  <= 1'b0;
      o_busy      <= 1'b0;
      o_grant     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (i_if_req || i_ls_req) begin
            state   <= ACCESS;
            o_busy  <= 1'b1;
            cnt     <= '0;
            last_ls <= pick_ls;
            if (pick_ls) begin
              o_grant     <= 2'b10;
              o_mem_addr  <= i_ls_addr;
              o_mem_wdata <= i_ls_wdata;
              o_mem_bmask <= i_ls_wren ? i_ls_bmask : 4'b1111;
              o_mem_wren  <= i_ls_wren;
              o_mem_rden  <= ~i_ls_wren;
            end else begin
              o_grant     <= 2'b01;
              o_mem_addr  <= i_if_addr;
              o_mem_wdata <= '0;
              o_mem_bmask <= 4'b1111;
              o_mem_wren  <= 1'b0;
              o_mem_rden  <= 1'b1;
            end
          end
        end

        ACCESS: begin
          cnt <= cnt + 8'd1;
          // Ack wins over a timeout that expires in the same cycle.
          if (i_mem_ack || cnt == CNT_LAST) begin
            state      <= RESP;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;
            o_err      <= ~i_mem_ack;
            if (o_grant[0]) begin
              o_if_ack   <= 1'b1;
              o_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
            end else begin
              o_ls_ack   <= 1'b1;
              o_ls_rdata <= (i_mem_ack && !o_mem_wren) ? i_mem_rdata : '0;
            end
          end
        end

        RESP: begin
          state      <= IDLE;
          o_if_ack   <= 1'b0;
          o_if_rdata <= '0;
          o_ls_ack   <= 1'b0;
          o_ls_rdata <= '0;
          o_err      <= 1'b0;
          o_busy     <= 1'b0;
          o_grant    <= 2'b00;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory model with programmable ack delay
// and a scoreboard of expected requester responses in issue order.
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        i_ls_req = 1'b0;
  logic        i_ls_wren = 1'b0;
  logic [31:0] i_ls_addr = '0;
  logic [31:0] i_ls_wdata = '0;
  logic [3:0]  i_ls_bmask = '0;
  logic        o_ls_ack;
  logic [31:0] o_ls_rdata;
  logic        o_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic        o_mem_rden;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_ack = 1'b0;
  logic        o_busy;
  logic [1:0]  o_grant;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
    .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_err(o_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  typedef struct {
    logic        ls;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] grant_log[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_run = 0;
  int last_run = 0;
  int ack_delay = 1;   // ack in this ACCESS cycle; 0 = never ack
  int ack_cnt = 0;
  int t0, t1, t2, t3, start;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic exp_t mk(input logic ls, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.ls = ls; e.rdata = rdata; e.err = err;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score any ack, then play memory.
  task automatic step();
    exp_t e;
    @(negedge i_clk);
    cyc++;
    if (o_if_ack || o_ls_ack) begin
      ack_cnt++;
      if (sb.size() == 0) check("unexpected_ack", {o_ls_ack, o_if_ack}, 32'd0);
      else begin
        e = sb.pop_front();
        check("ack_port", {o_ls_ack, o_if_ack}, e.ls ? 32'd2 : 32'd1);
        check("ack_grant", o_grant, e.ls ? 32'd2 : 32'd1);
        check("ack_rdata", e.ls ? o_ls_rdata : o_if_rdata, e.rdata);
        check("other_rdata", e.ls ? o_if_rdata : o_ls_rdata, 32'd0);
        check("ack_err", o_err, e.err);
      end
    end
    if (o_mem_rden || o_mem_wren) begin
      if (acc_run == 0) grant_log.push_back(o_grant);
      acc_run++;
      last_run = acc_run;
      if (ack_delay != 0 && acc_run == ack_delay) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = o_mem_wren ? 32'hFFFF_FFFF : mem_word(o_mem_addr);
      end else begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h5A5A_5A5A;
      end
    end else begin
      acc_run     = 0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h5A5A_5A5A;
    end
  endtask

  task automatic wait_ack(input int budget);
    int n0;
    n0 = ack_cnt;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ack_cnt != n0) return;
    end
    check("ack_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset with both requests pending.
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h80;
    i_ls_wdata = 32'hAAAA_5555; i_ls_bmask = 4'b0101;
    step(); step();
    check("rst_busy", o_busy, 32'd0);
    check("rst_grant", o_grant, 32'd0);
    check("rst_acks", {o_ls_ack, o_if_ack, o_err}, 32'd0);
    check("rst_strobes", {o_mem_wren, o_mem_rden}, 32'd0);
    check("rst_addr", o_mem_addr, 32'd0);
    check("rst_wdata", o_mem_wdata, 32'd0);
    check("rst_bmask", o_mem_bmask, 32'd0);
    check("rst_rdata", o_if_rdata | o_ls_rdata, 32'd0);

    // First tie after reset goes to load/store, then fetch.
    sb.push_back(mk(1'b1, mem_word(32'h80), 1'b0));
    sb.push_back(mk(1'b0, mem_word(32'h40), 1'b0));
    i_rst = 1'b1;
    step();
    check("first_grant", o_grant, 32'd2);
    check("first_busy", o_busy, 32'd1);
    wait_ack(10);
    i_ls_req = 1'b0;
    wait_ack(10);
    i_if_req = 1'b0;
    step();

    // Continuous dual requests alternate LS, IF, LS, IF at 3-cycle intervals.
    grant_log.delete();
    i_if_addr = 32'h300; i_ls_addr = 32'h400;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(1'b1, mem_word(32'h400), 1'b0));
      sb.push_back(mk(1'b0, mem_word(32'h300), 1'b0));
    end
    i_if_req = 1'b1; i_ls_req = 1'b1;
    wait_ack(10); t0 = cyc;
    wait_ack(10); t1 = cyc;
    wait_ack(10); t2 = cyc;
    wait_ack(10); t3 = cyc;
    i_if_req = 1'b0; i_ls_req = 1'b0;
    check("rr_count", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      check("rr_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 32'b10011001);
    end
    check("rr_interval", {t1 - t0, t2 - t1, t3 - t2}, {32'd3, 32'd3, 32'd3});
    step();

    // Zero-wait fetch.
    i_if_addr = 32'h100; i_if_req = 1'b1; start = cyc;
    sb.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b0));
    step();
    check("fetch_rden", {o_mem_wren, o_mem_rden}, 32'd1);
    check("fetch_bmask", o_mem_bmask, 32'hF);
    check("fetch_addr", o_mem_addr, 32'h100);
    wait_ack(10);
    i_if_req = 1'b0;
    check("fetch_latency", cyc - start, 32'd2);
    check("fetch_strobe_len", last_run, 32'd1);
    step();
    check("idle_after_fetch", {o_busy, o_grant}, 32'd0);

    // Store acknowledged in the third ACCESS cycle.
    ack_delay = 3;
    i_ls_addr = 32'h2004; i_ls_wdata = 32'h1234_5678; i_ls_bmask = 4'b0011;
    i_ls_wren = 1'b1; i_ls_req = 1'b1;
    sb.push_back(mk(1'b1, 32'd0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      step();
      check("store_strobes", {o_mem_wren, o_mem_rden}, 32'd2);
      check("store_fields", {o_mem_addr, o_mem_wdata}, {32'h2004, 32'h1234_5678});
      check("store_bmask", o_mem_bmask, 32'h3);
    end
    wait_ack(10);
    i_ls_req = 1'b0; i_ls_wren = 1'b0;
    check("store_strobe_len", last_run, 32'd3);
    step();

    // Memory never acks: strobe lasts TIMEOUT cycles, then error response.
    ack_delay = 0;
    i_ls_addr = 32'h500; i_ls_req = 1'b1;
    sb.push_back(mk(1'b1, 32'd0, 1'b1));
    wait_ack(20);
    i_ls_req = 1'b0;
    check("timeout_strobe_len", last_run, TIMEOUT);
    step();
    ack_delay = 1;
    i_if_addr = 32'h600; i_if_req = 1'b1;
    sb.push_back(mk(1'b0, mem_word(32'h600), 1'b0));
    wait_ack(10);
    i_if_req = 1'b0;
    check("after_timeout_err", o_err, 32'd0);
    step();

    // Inputs that change during ACCESS are ignored until IDLE.
    ack_delay = 3;
    i_if_addr = 32'h700; i_if_req = 1'b1;
    sb.push_back(mk(1'b0, mem_word(32'h700), 1'b0));
    step();
    check("hold_addr0", o_mem_addr, 32'h700);
    i_if_addr = 32'h7FC;
    i_ls_addr = 32'h800; i_ls_req = 1'b1;
    sb.push_back(mk(1'b1, mem_word(32'h800), 1'b0));
    step();
    check("hold_addr1", o_mem_addr, 32'h700);
    check("hold_grant", o_grant, 32'd1);
    wait_ack(10);
    i_if_req = 1'b0;
    wait_ack(20);
    i_ls_req = 1'b0;
    step();

    // Reset during ACCESS aborts without an ack.
    ack_delay = 0;
    i_ls_addr = 32'h900; i_ls_req = 1'b1;
    step();
    check("abort_pre_strobe", o_mem_rden, 32'd1);
    i_rst = 1'b0;
    step();
    check("abort_strobes", {o_mem_wren, o_mem_rden}, 32'd0);
    check("abort_state", {o_busy, o_grant, o_if_ack, o_ls_ack}, 32'd0);
    i_rst = 1'b1; i_ls_req = 1'b0;
    step(); step();
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
